// File: rtl/alu_sched_pkg.sv
// ---------------------------------------------------------------------------
// alu_sched_pkg
//   Shared definitions for the round-robin ALU scheduler:
//     - ALU opcode constants (3-bit sel encoding)
//     - scheduler FSM state encoding
//     - lat_of(): number of EXEC cycles an opcode occupies the shared ALU
// ---------------------------------------------------------------------------
package alu_sched_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    // Width of the EXEC latency counter; latencies up to 255 cycles.
    localparam int CNTW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // EXEC cycles for an opcode: MUL and DIV are configurable, all others take one.
    function automatic logic [CNTW-1:0] lat_of(input logic [2:0]      sel,
                                               input logic [CNTW-1:0] mul_lat,
                                               input logic [CNTW-1:0] div_lat);
        case (sel)
            OP_MUL:  return mul_lat;
            OP_DIV:  return div_lat;
            default: return CNTW'(1);
        endcase
    endfunction

endpackage

// File: rtl/basic_alu_unit.sv
// ---------------------------------------------------------------------------
// basic_alu_unit
//   Purely combinational 8-bit ALU shared by all requesters.
//   Ports:
//     a, b  in  8  operands
//     sel   in  3  opcode (000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 SHL,
//                  101 SHR, 110 NAND, 111 XOR)
//     y     out 8  result, modulo 256; DIV by zero yields 0
// ---------------------------------------------------------------------------
module basic_alu_unit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] sel,
    output logic [7:0] y
);

    always_comb begin
        y = '0;
        case (sel)
            3'b000: y = a + b;
            3'b001: y = a - b;
            3'b010: y = a * b;                       // low byte only
            3'b011: y = (b == 8'd0) ? 8'd0 : a / b;  // guard keeps X out of the datapath
            3'b100: y = {a[6:0], 1'b0};
            3'b101: y = {1'b0, a[7:1]};
            3'b110: y = ~(a & b);
            3'b111: y = a ^ b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Rotating-priority arbiter. The search starts at (ptr+1) and wraps, so the
//   requester granted last (ptr) has the lowest priority next time.
//   Ports:
//     req        in  NREQ  request vector
//     ptr        in  IDW   index of the most recently granted requester
//     grant      out NREQ  one-hot grant (all zero when no request)
//     grant_id   out IDW   index of the granted requester
//     grant_vld  out 1     some requester is granted
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            grant_vld
);

    // Two priority passes: indices above ptr win over indices at/below ptr,
    // and within each pass the lowest index wins. Together they implement the
    // wrapped search without any modulo arithmetic.
    logic [NREQ-1:0] hi_oh, lo_oh;
    logic [IDW-1:0]  hi_id, lo_id;
    logic            hi_vld, lo_vld;

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        hi_oh  = '0;
        lo_oh  = '0;
        hi_id  = '0;
        lo_id  = '0;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!hi_vld && req[i] && (i > int'(ptr))) begin
                hi_vld   = 1'b1;
                hi_oh[i] = 1'b1;
                hi_id    = IDW'(i);
            end
            if (!lo_vld && req[i] && (i <= int'(ptr))) begin
                lo_vld   = 1'b1;
                lo_oh[i] = 1'b1;
                lo_id    = IDW'(i);
            end
        end
    end

    assign grant     = hi_vld ? hi_oh : lo_oh;
    assign grant_id  = hi_vld ? hi_id : lo_id;
    assign grant_vld = hi_vld | lo_vld;

endmodule

// File: rtl/alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// alu_rr_scheduler
//   Shares one basic_alu_unit between NREQ requesters. A round-robin arbiter
//   picks one request in IDLE, the operands are registered, the op occupies
//   EXEC for lat(sel) cycles, and the tagged result is held in RESP until the
//   consumer accepts it. Only one operation is in flight at a time.
//   Ports:
//     clk        in  1       clock, rising edge
//     rst_n      in  1       asynchronous active-low reset
//     req_valid  in  NREQ    per-requester request valid
//     req_ready  out NREQ    per-requester accept, one-hot in IDLE, else 0
//     req_a      in  8*NREQ  operand A, slice i for requester i
//     req_b      in  8*NREQ  operand B, slice i for requester i
//     req_sel    in  3*NREQ  opcode, slice i for requester i
//     rsp_valid  out 1       result valid (state RESP)
//     rsp_ready  in  1       consumer accepts the result
//     rsp_id     out IDW     requester the result belongs to
//     rsp_data   out 8       ALU result
//     rsp_dz     out 1       divide-by-zero flag
//     busy       out 1       state is not IDLE
// ---------------------------------------------------------------------------
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_data,
    output logic              rsp_dz,
    output logic              busy
);

    localparam logic [CNTW-1:0] MUL_L = CNTW'(MUL_LAT);
    localparam logic [CNTW-1:0] DIV_L = CNTW'(DIV_LAT);

    state_t            state, state_nxt;
    logic [IDW-1:0]    ptr;
    logic [7:0]        op_a, op_b;
    logic [2:0]        op_sel;
    logic [IDW-1:0]    op_id;
    logic [CNTW-1:0]   cnt;

    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_id;
    logic              grant_vld;
    logic [7:0]        g_a, g_b;
    logic [2:0]        g_sel;
    logic [7:0]        alu_y;
    logic              req_hs;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .grant_vld (grant_vld)
    );

    // The ALU only ever sees registered operands, so requester inputs
    // changing during EXEC cannot disturb the result.
    basic_alu_unit u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .y   (alu_y)
    );

    // Operand mux for the granted requester; the grant is one-hot, so an
    // AND-OR selection is sufficient.
    always_comb begin
        g_a   = '0;
        g_b   = '0;
        g_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_a   = g_a   | req_a[i*8 +: 8];
                g_b   = g_b   | req_b[i*8 +: 8];
                g_sel = g_sel | req_sel[i*3 +: 3];
            end
        end
    end

    // A grant is only issued to a valid requester, so in IDLE the grant alone
    // means the request handshake completes at this edge.
    assign req_hs = (state == ST_IDLE) && grant_vld;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                busy      = 1'b0;
                req_ready = grant;
                if (req_hs) state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt == '0) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= IDW'(NREQ - 1);  // requester 0 is searched first
            op_a     <= '0;
            op_b     <= '0;
            op_sel   <= '0;
            op_id    <= '0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
            rsp_dz   <= 1'b0;
        end else begin
            if (req_hs) begin
                op_a   <= g_a;
                op_b   <= g_b;
                op_sel <= g_sel;
                op_id  <= grant_id;
                ptr    <= grant_id;
                // Counter holds the number of EXEC cycles still to go after
                // the current one.
                cnt    <= lat_of(g_sel, MUL_L, DIV_L) - CNTW'(1);
            end
            if (state == ST_EXEC) begin
                if (cnt != '0) begin
                    cnt <= cnt - CNTW'(1);
                end else begin
                    rsp_data <= alu_y;
                    rsp_id   <= op_id;
                    rsp_dz   <= (op_sel == OP_DIV) && (op_b == 8'd0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// ---------------------------------------------------------------------------
// tb_alu_rr_scheduler
//   Self-checking bench: a vector table of single-requester operations,
//   hand-written multi-cycle sequences (all-valid rotation, response
//   back-pressure, reset mid-DIV) and randomized multi-requester traffic,
//   all compared against an arithmetic reference model kept here.
// ---------------------------------------------------------------------------
module tb_alu_rr_scheduler;

    localparam int NREQ    = 4;
    localparam int IDW     = 2;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_data;
    logic              rsp_dz;
    logic              busy;

    int n_cmp = 0;
    int n_bad = 0;
    int model_last;  // last requester granted, per the reference model

    alu_rr_scheduler #(
        .NREQ    (NREQ),
        .IDW     (IDW),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_dz    (rsp_dz),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int ref_alu(input int a, input int b, input int sel);
        case (sel)
            0: return (a + b) % 256;
            1: return (a - b + 256) % 256;
            2: return (a * b) % 256;
            3: return (b == 0) ? 0 : a / b;
            4: return (a * 2) % 256;
            5: return a / 2;
            6: return 255 - (a & b);
            default: return a ^ b;
        endcase
    endfunction

    function automatic int ref_lat(input int sel);
        if (sel == 2) return MUL_LAT;
        if (sel == 3) return DIV_LAT;
        return 1;
    endfunction

    function automatic int ref_grant(input int mask, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input int a, input int b, input int sel);
        req_a[i*8 +: 8]   = 8'(a);
        req_b[i*8 +: 8]   = 8'(b);
        req_sel[i*3 +: 3] = 3'(sel);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        rst_n      = 1'b1;
        model_last = NREQ - 1;
    endtask

    // One complete transaction; caller has already driven req_valid/operands.
    // hold = cycles rsp_ready stays low while the response is presented.
    task automatic run(input string tag, input int exp_id, input int exp_data,
                       input int exp_dz, input int exp_lat, input int hold);
        int n;
        #1;
        check({tag, " req_ready"}, req_ready, 1 << exp_id);
        step();                       // handshake edge
        req_valid = '0;
        #1;
        check({tag, " busy"}, busy, 1);
        n = 0;
        while (!rsp_valid && n < 16) begin
            step();
            n++;
            #1;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " data"}, rsp_data, exp_data);
        check({tag, " id"}, rsp_id, exp_id);
        check({tag, " dz"}, rsp_dz, exp_dz);
        for (int h = 0; h < hold; h++) begin
            step();
            #1;
            check({tag, " hold valid"}, rsp_valid, 1);
            check({tag, " hold data"}, rsp_data, exp_data);
            check({tag, " hold ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        step();                       // accept edge
        rsp_ready = 1'b0;
        #1;
        check({tag, " valid after accept"}, rsp_valid, 0);
        check({tag, " idle after accept"}, busy, 0);
        model_last = exp_id;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int id;
        int a;
        int b;
        int sel;
        int data;
        int dz;
        int lat;
    } vec_t;

    vec_t vt[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int got, exp;
        int ra[NREQ], rb[NREQ], rs[NREQ];

        vt[0]  = '{0, 200, 100, 0,  44, 0, 1};
        vt[1]  = '{2,  16,  17, 2,  16, 0, 2};
        vt[2]  = '{1,  50,   0, 3,   0, 1, 4};
        vt[3]  = '{1,  50,   7, 3,   7, 0, 4};
        vt[4]  = '{3,   5,  10, 1, 251, 0, 1};
        vt[5]  = '{0, 129,   0, 4,   2, 0, 1};
        vt[6]  = '{2, 129,   0, 5,  64, 0, 1};
        vt[7]  = '{1, 240,  60, 6, 207, 0, 1};
        vt[8]  = '{3, 240,  60, 7, 204, 0, 1};
        vt[9]  = '{0, 255, 255, 2,   1, 0, 2};
        vt[10] = '{2,   0,   5, 3,   0, 0, 4};
        vt[11] = '{3, 255,   1, 0,   0, 0, 1};

        req_a     = '0;
        req_b     = '0;
        req_sel   = '0;
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b0;
        #3;
        check("reset rsp_valid", rsp_valid, 0);
        check("reset busy", busy, 0);
        check("reset req_ready", req_ready, 0);
        check("reset rsp_data", rsp_data, 0);
        check("reset rsp_id", rsp_id, 0);
        check("reset rsp_dz", rsp_dz, 0);
        do_reset();

        // Table-driven single-requester operations
        for (int i = 0; i < 12; i++) begin
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].sel);
            req_valid = NREQ'(1 << vt[i].id);
            run($sformatf("vec%0d", i), vt[i].id, vt[i].data, vt[i].dz, vt[i].lat, i % 3);
        end

        // All requesters valid: rotation 0,1,2,3,0,1 and one-hot ready only in IDLE
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, i * 10, 1, 0);
        req_valid = '1;
        rsp_ready = 1'b1;
        exp = 0;
        got = 0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            #1;
            if (busy) check("rot ready when busy", req_ready, 0);
            else      check("rot ready one-hot", req_ready, 1 << exp);
            if (rsp_valid) begin
                check("rot id", rsp_id, exp);
                check("rot data", rsp_data, exp * 10 + 1);
                got++;
                exp = (exp + 1) % NREQ;
            end
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rot response count", got, 6);
        model_last = 1;

        // Back-pressure: response held 5 cycles while another request waits
        set_req(1, 3, 4, 0);
        req_valid = 4'b0010;
        #1;
        check("bp req_ready", req_ready, 4'b0010);
        step();
        set_req(3, 9, 6, 7);
        req_valid = 4'b1000;
        got = 0;
        #1;
        while (!rsp_valid && got < 16) begin
            step();
            got++;
            #1;
        end
        check("bp latency", got, 1);
        for (int h = 0; h < 5; h++) begin
            step();
            #1;
            check("bp hold valid", rsp_valid, 1);
            check("bp hold data", rsp_data, 7);
            check("bp hold id", rsp_id, 1);
            check("bp hold req_ready", req_ready, 0);
            check("bp hold busy", busy, 1);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        #1;
        check("bp idle after release", busy, 0);
        model_last = 1;
        run("bp next", 3, 15, 0, 1, 0);

        // Reset in the middle of a DIV
        set_req(2, 50, 5, 3);
        req_valid = 4'b0100;
        #1;
        check("rst req_ready", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst rsp_valid", rsp_valid, 0);
        check("rst busy", busy, 0);
        check("rst rsp_data", rsp_data, 0);
        check("rst rsp_id", rsp_id, 0);
        check("rst rsp_dz", rsp_dz, 0);
        check("rst req_ready", req_ready, 0);
        step();
        rst_n      = 1'b1;
        model_last = NREQ - 1;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (rsp_valid || busy) got++;
        end
        check("rst no stray response", got, 0);
        for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 2, 2);
        req_valid = '1;
        run("rst next grant", 0, 2, 0, MUL_LAT, 0);

        // Randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            int mask, g;
            mask = int'($urandom_range(1, (1 << NREQ) - 1));
            for (int i = 0; i < NREQ; i++) begin
                ra[i] = int'($urandom_range(0, 255));
                rb[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255));
                rs[i] = int'($urandom_range(0, 7));
                set_req(i, ra[i], rb[i], rs[i]);
            end
            req_valid = NREQ'(mask);
            g = ref_grant(mask, model_last);
            run($sformatf("rand%0d", t), g, ref_alu(ra[g], rb[g], rs[g]),
                (rs[g] == 3 && rb[g] == 0) ? 1 : 0, ref_lat(rs[g]),
                int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
